// File: rtl/gd_pkg.sv
// Shared definitions for the gradient-descent step controller.
//   QW          : Q24.8 word width
//   FRAC_BITS   : fractional bits of the Q24.8 format
//   Q_MAX/Q_MIN : saturation limits for signed Q24.8 arithmetic
//   gd_state_e  : iteration FSM states
package gd_pkg;

  localparam int unsigned QW        = 32;
  localparam int unsigned FRAC_BITS = 8;

  localparam logic [QW-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [QW-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StUpdate,
    StCheck,
    StDone
  } gd_state_e;

endpackage

// File: rtl/fixed_32_sat_sub.sv
// 32-bit signed saturating subtract, purely combinational.
//   a_i : minuend (signed Q24.8)
//   b_i : subtrahend (signed Q24.8)
//   y_o : a_i - b_i clamped to [Q_MIN, Q_MAX]
module fixed_32_sat_sub
  import gd_pkg::*;
(
  input  logic [QW-1:0] a_i,
  input  logic [QW-1:0] b_i,
  output logic [QW-1:0] y_o
);

  logic [QW:0] sum;

  always_comb begin
    sum = {a_i[QW-1], a_i} - {b_i[QW-1], b_i};
    // Top two bits disagree only when the true result left the 32-bit range;
    // bit 32 then carries the real sign and picks the rail.
    if (sum[QW] != sum[QW-1]) begin
      y_o = sum[QW] ? Q_MIN : Q_MAX;
    end else begin
      y_o = sum[QW-1:0];
    end
  end

endmodule

// File: rtl/gd_step_ctrl.sv
// Iteration controller for 1-D gradient descent in Q24.8 fixed point.
// Requests the gradient at the current point, steps x by -(g >>> LR_SHIFT)
// with saturation, and stops on a small step or on the iteration limit.
//   clk, rst_n              : clock, synchronous active-low reset
//   start, x_init           : begin a run from x_init (accepted in idle/done only)
//   req_valid/req_ready     : gradient request handshake, req_x = current x
//   grad_valid, grad_in     : gradient result, consumed only while waiting
//   busy, done              : run in progress / one-cycle completion pulse
//   converged, timeout      : sticky result flags, meaningful in done
//   x_out, iter_count       : current/final x and number of completed updates
module gd_step_ctrl
  import gd_pkg::*;
#(
  parameter int unsigned   LR_SHIFT         = 4,
  parameter int unsigned   MAX_ITER         = 1024,
  parameter logic [QW-1:0] LOWER_CONV_BOUND = 32'hFFFF_FFC0,
  parameter logic [QW-1:0] UPPER_CONV_BOUND = 32'h0000_0040
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [QW-1:0] x_init,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [QW-1:0] req_x,
  input  logic          grad_valid,
  input  logic [QW-1:0] grad_in,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic          timeout,
  output logic [QW-1:0] x_out,
  output logic [15:0]   iter_count
);

  localparam logic [15:0] MaxIterW = 16'(MAX_ITER);

  gd_state_e     state_q, state_d;
  logic [QW-1:0] x_q, x_d;
  logic [QW-1:0] grad_q, grad_d;
  logic [QW-1:0] diff_q, diff_d;
  logic [15:0]   iter_q, iter_d;
  logic          conv_q, conv_d;
  logic          tmo_q, tmo_d;
  logic          done_q, done_d;

  logic [QW-1:0] step;
  logic [QW-1:0] x_next;
  logic [QW-1:0] diff_next;
  logic          in_window;
  logic          iter_at_max;

  // Arithmetic shift floors toward -inf, so a small negative gradient still moves x by +1 LSB.
  assign step = $signed(grad_q) >>> LR_SHIFT;

  fixed_32_sat_sub u_sub_x (
    .a_i (x_q),
    .b_i (step),
    .y_o (x_next)
  );

  // Measured step is taken after saturation, so a clamped x reports the step it really made.
  fixed_32_sat_sub u_sub_diff (
    .a_i (x_next),
    .b_i (x_q),
    .y_o (diff_next)
  );

  assign in_window   = ($signed(diff_q) > $signed(LOWER_CONV_BOUND)) &&
                       ($signed(diff_q) < $signed(UPPER_CONV_BOUND));
  assign iter_at_max = (iter_q == MaxIterW);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    grad_d  = grad_q;
    diff_d  = diff_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          x_d     = x_init;
          iter_d  = '0;
          conv_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (grad_valid) begin
          grad_d  = grad_in;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        x_d     = x_next;
        diff_d  = diff_next;
        iter_d  = (iter_q == 16'hFFFF) ? iter_q : iter_q + 16'd1;
        state_d = StCheck;
      end
      StCheck: begin
        // Converged takes priority when the last allowed step also lands in the window.
        conv_d = in_window;
        tmo_d  = !in_window && iter_at_max;
        if (in_window || iter_at_max) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      grad_q  <= '0;
      diff_q  <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      grad_q  <= grad_d;
      diff_q  <= diff_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    req_valid  = (state_q == StReq);
    req_x      = x_q;
    busy       = (state_q == StReq) || (state_q == StWait) ||
                 (state_q == StUpdate) || (state_q == StCheck);
    done       = done_q;
    converged  = conv_q;
    timeout    = tmo_q;
    x_out      = x_q;
    iter_count = iter_q;
  end

endmodule

// File: tb/tb_gd_step_ctrl.sv
module tb_gd_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] x_init;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x;
  logic        grad_valid;
  logic [31:0] grad_in;
  logic        busy;
  logic        done;
  logic        converged;
  logic        timeout;
  logic [31:0] x_out;
  logic [15:0] iter_count;

  always #5 clk = ~clk;

  gd_step_ctrl #(
    .LR_SHIFT (4),
    .MAX_ITER (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x_init     (x_init),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .grad_valid (grad_valid),
    .grad_in    (grad_in),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .timeout    (timeout),
    .x_out      (x_out),
    .iter_count (iter_count)
  );

  typedef struct {
    logic [31:0] x;
    logic [15:0] iter;
    logic        conv;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        mon_e = sb.pop_front();
        check32("x_out", x_out, mon_e.x);
        check32("iter_count", {16'h0, iter_count}, {16'h0, mon_e.iter});
        check32("converged", {31'h0, converged}, {31'h0, mon_e.conv});
        check32("timeout", {31'h0, timeout}, {31'h0, mon_e.tmo});
        check32("busy_at_done", {31'h0, busy}, 32'h0);
      end
    end
  end

  task automatic do_start(input logic [31:0] x0, input bit push, input exp_t e);
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start  = 1'b1;
    x_init = x0;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Answer one gradient request; optionally stall req_ready and poke start while busy.
  task automatic serve(input logic [31:0] g, input int hold, input bit poke);
    bit          seen = 1'b0;
    logic [31:0] rx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got no req_valid expected request within 50 cycles");
      return;
    end
    rx = req_x;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (poke && k == 3) begin
        start  = 1'b1;
        x_init = 32'h1234_0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check32("req_valid_hold", {31'h0, req_valid}, 32'h1);
      check32("req_x_hold", req_x, rx);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready  = 1'b0;
    grad_valid = 1'b1;
    grad_in    = g;
    @(negedge clk);
    check32("req_valid_drop", {31'h0, req_valid}, 32'h0);
    @(posedge clk); #1;
    grad_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got busy=1 expected completion within 60 cycles");
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run1(input logic [31:0] x0, input logic [31:0] g, input exp_t e);
    do_start(x0, 1'b1, e);
    serve(g, 0, 1'b0);
    wait_done();
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_req_valid"}, {31'h0, req_valid}, 32'h0);
    check32({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check32({tag, "_done"}, {31'h0, done}, 32'h0);
    check32({tag, "_converged"}, {31'h0, converged}, 32'h0);
    check32({tag, "_timeout"}, {31'h0, timeout}, 32'h0);
    check32({tag, "_x_out"}, x_out, 32'h0);
    check32({tag, "_iter_count"}, {16'h0, iter_count}, 32'h0);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    rst_n      = 1'b0;
    start      = 1'b0;
    x_init     = 32'h0;
    req_ready  = 1'b0;
    grad_valid = 1'b0;
    grad_in    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: step 0x10, diff -0x10 converges at once
    e = '{x: 32'h0000_09F0, iter: 16'd1, conv: 1'b1, tmo: 1'b0};
    run1(32'h0000_0A00, 32'h0000_0100, e);

    // 2: diffs -0x100, -0x40 (exclusive bound), -0x3F; x ends at -0x17F
    e = '{x: 32'hFFFF_FE81, iter: 16'd3, conv: 1'b1, tmo: 1'b0};
    do_start(32'h0, 1'b1, e);
    serve(32'h0000_1000, 0, 1'b0);
    serve(32'h0000_0400, 0, 1'b0);
    serve(32'h0000_03F0, 0, 1'b0);
    wait_done();

    // 3: saturation at both rails, floor of a small negative step
    e = '{x: 32'h8000_0000, iter: 16'd1, conv: 1'b1, tmo: 1'b0};
    run1(32'h8000_0010, 32'h7FFF_FFF0, e);
    e = '{x: 32'h8000_0001, iter: 16'd1, conv: 1'b1, tmo: 1'b0};
    run1(32'h8000_0000, 32'hFFFF_FFF0, e);
    e = '{x: 32'h7FFF_FFFF, iter: 16'd1, conv: 1'b1, tmo: 1'b0};
    run1(32'h7FFF_FFF0, 32'h8000_0000, e);

    // 4: never in window, stops on the iteration limit
    e = '{x: 32'hFFFF_FC00, iter: 16'd4, conv: 1'b0, tmo: 1'b1};
    do_start(32'h0, 1'b1, e);
    repeat (4) serve(32'h0000_1000, 0, 1'b0);
    wait_done();

    // Last allowed iteration also lands in the window: converged, no timeout
    e = '{x: 32'hFFFF_FCF0, iter: 16'd4, conv: 1'b1, tmo: 1'b0};
    do_start(32'h0, 1'b1, e);
    repeat (3) serve(32'h0000_1000, 0, 1'b0);
    serve(32'h0000_0100, 0, 1'b0);
    wait_done();

    // 5: stalled handshake with a start pulse while busy
    e = '{x: 32'h0000_09F0, iter: 16'd1, conv: 1'b1, tmo: 1'b0};
    do_start(32'h0000_0A00, 1'b1, e);
    serve(32'h0000_0100, 10, 1'b1);
    wait_done();

    // 6: reset while waiting for the gradient, then a late grad_valid
    e = '{x: 32'h0, iter: 16'd0, conv: 1'b0, tmo: 1'b0};
    do_start(32'h0000_0A00, 1'b0, e);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check32("t6_req_seen", {31'h0, seen}, 32'h1);
    @(posedge clk); #1 req_ready = 1'b1;
    @(posedge clk); #1 req_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; grad_valid = 1'b1; grad_in = 32'h0000_0100;
    @(posedge clk); #1 grad_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_reset");

    // Controller still usable after the mid-run reset
    e = '{x: 32'h0000_09F0, iter: 16'd1, conv: 1'b1, tmo: 1'b0};
    run1(32'h0000_0A00, 32'h0000_0100, e);

    check32("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish before 200us");
    $fatal(1);
  end

endmodule
